// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS controller sequencing fetch/decode/execute/memory/writeback
// with a memory-ready stall handshake and a retired-instruction counter.
module mc_control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_write,
  output logic        iord,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_control,
  output logic [3:0]  state,
  output logic [31:0] instr_count
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                         MEMWB = 4'd4, MEMWRITE = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7,
                         BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  logic [3:0]  state_q, state_d;
  logic [31:0] count_q, count_d;
  logic        pc_write, branch, ir_wr, reg_wr, mem_wr, retire;
  always_comb begin
    state_d     = FETCH;
    pc_write    = 1'b0;
    branch      = 1'b0;
    ir_wr       = 1'b0;
    reg_wr      = 1'b0;
    mem_wr      = 1'b0;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    alu_control = 3'b010;
    case (state_q)
      FETCH: begin
        alu_src_b = 2'b01;
        ir_wr     = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        state_d   = (op == OP_LW || op == OP_SW) ? MEMADR :
                    op == OP_R    ? EXECUTE :
                    op == OP_BEQ  ? BRANCH  :
                    op == OP_ADDI ? ADDIEX  :
                    op == OP_J    ? JUMP    : FETCH;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = op == OP_LW ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        iord    = 1'b1;
        state_d = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_wr     = 1'b1;
      end
      MEMWRITE: begin
        iord    = 1'b1;
        mem_wr  = 1'b1;
        state_d = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = funct == 6'b100010 ? 3'b110 :
                      funct == 6'b100100 ? 3'b000 :
                      funct == 6'b100101 ? 3'b001 :
                      funct == 6'b101010 ? 3'b111 : 3'b010;
        state_d     = ALUWB;
      end
      ALUWB: begin
        reg_dst = 1'b1;
        reg_wr  = 1'b1;
      end
      BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = 3'b110;
        branch      = 1'b1;
        pc_src      = 2'b01;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: reg_wr = 1'b1;
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end
  // only completing instructions retire; an unknown op falling back from DECODE does not
  assign retire  = state_d == FETCH && (state_q inside {MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP});
  assign count_d = count_q + {31'd0, retire};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end
  // strobes gated by rst_n so nothing writes while reset is held
  assign pc_en       = rst_n & (pc_write | (branch & zero));
  assign ir_write    = rst_n & ir_wr;
  assign reg_write   = rst_n & reg_wr;
  assign mem_write   = rst_n & mem_wr;
  assign state       = state_q;
  assign instr_count = count_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: random instruction stream against a phase-list reference model of the controller.
module tb_mc_control_fsm;
  localparam int T_LW = 0, T_SW = 1, T_R = 2, T_ADDI = 3, T_BEQ = 4, T_J = 5, T_UNK = 6;
  logic        clk = 1'b0;
  logic        rst_n, zero, mem_ready;
  logic [5:0]  op, funct;
  logic        pc_en, ir_write, reg_write, mem_write, iord, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_control;
  logic [3:0]  state;
  logic [31:0] instr_count;
  logic [31:0] cnt_m;
  int          total = 0;
  int          bad = 0;
  logic [5:0]  ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
  logic [5:0]  fl  [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27};

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_write(ir_write), .reg_write(reg_write), .mem_write(mem_write),
    .iord(iord), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_control(alu_control), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // one instruction from FETCH back to FETCH; fs/ms = stall cycles in fetch and in the data access
  task automatic run(input int t, input logic [5:0] o, input logic [5:0] f, input logic z,
                     input int fs, input int ms);
    int q[$];
    int n, seq_bad, irc, rwc, mwc, pcc;
    logic r;
    logic memop;
    logic [8:0] fv;
    logic [5:0] dv, ev, ev_exp;
    logic [4:0] wv, wv_exp;
    seq_bad = 0; irc = 0; rwc = 0; mwc = 0; pcc = 0;
    fv = '0; dv = '0; ev = '0; wv = '0;
    memop = (t == T_LW || t == T_SW);
    op = o;
    funct = f;
    for (int i = 0; i <= fs; i++) q.push_back(0);
    q.push_back(1);
    case (t)
      T_LW:   begin q.push_back(2); for (int i = 0; i <= ms; i++) q.push_back(3); q.push_back(4); end
      T_SW:   begin q.push_back(2); for (int i = 0; i <= ms; i++) q.push_back(5); end
      T_R:    begin q.push_back(6); q.push_back(7); end
      T_ADDI: begin q.push_back(9); q.push_back(10); end
      T_BEQ:  q.push_back(8);
      T_J:    q.push_back(11);
      default: ;
    endcase
    n = q.size();
    for (int k = 0; k < n; k++) begin
      r = k < fs ? 1'b0 : k == fs ? 1'b1 :
          (memop && k >= fs + 3) ? (k < fs + 3 + ms ? 1'b0 : 1'b1) : 1'($urandom_range(0, 1));
      mem_ready = r;
      zero = z;
      @(negedge clk);
      if (state !== 4'(q[k])) seq_bad++;
      irc += int'(ir_write);
      rwc += int'(reg_write);
      mwc += int'(mem_write);
      pcc += int'(pc_en);
      if (k == 0) fv = {iord, alu_src_a, alu_src_b, alu_control, pc_src};
      if (k == fs + 1) dv = {alu_src_a, alu_src_b, alu_control};
      if (k == fs + 2) ev = {alu_src_a, alu_src_b, alu_control};
      if (k == n - 1) wv = {reg_dst, mem_to_reg, pc_src, iord};
      @(posedge clk);
      #1;
    end
    if (t != T_UNK) cnt_m = cnt_m + 32'd1;
    ev_exp = t == T_R ? {3'b100, alu_of(f)} : t == T_BEQ ? 6'b100110 :
             t == T_J ? 6'b000010 : 6'b110010;
    wv_exp = t == T_LW ? 5'b01000 : t == T_SW ? 5'b00001 : t == T_R ? 5'b10000 :
             t == T_BEQ ? 5'b00010 : t == T_J ? 5'b00100 : 5'b00000;
    check("seq", 32'(seq_bad), 32'd0);
    check("fetch_sel", 32'(fv), 32'(9'b0_0_01_010_00));
    check("decode_sel", 32'(dv), 32'(6'b0_11_010));
    check("ir_write", 32'(irc), 32'd1);
    check("reg_write", 32'(rwc), (t == T_LW || t == T_R || t == T_ADDI) ? 32'd1 : 32'd0);
    check("mem_write", 32'(mwc), t == T_SW ? 32'(ms + 1) : 32'd0);
    check("pc_en", 32'(pcc), 32'(1 + (t == T_J ? 1 : 0) + ((t == T_BEQ && z) ? 1 : 0)));
    if (t != T_UNK) check("exec_sel", 32'(ev), 32'(ev_exp));
    if (t != T_UNK) check("wb_sel", 32'(wv), 32'(wv_exp));
    check("end_state", 32'(state), 32'd0);
    check("instr_count", instr_count, cnt_m);
  endtask

  initial begin
    int t, fs, ms;
    logic [5:0] o;
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; op = 6'b0; funct = 6'b0;
    cnt_m = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", instr_count, 32'd0);
    check("rst_strobes", 32'({pc_en, ir_write, reg_write, mem_write}), 32'd0);
    check("rst_sel", 32'({iord, alu_src_a, alu_src_b, alu_control, pc_src}), 32'(9'b0_0_01_010_00));
    rst_n = 1'b1;
    run(T_R, 6'b000000, 6'b101010, 1'b0, 0, 0);
    run(T_LW, 6'b100011, 6'h20, 1'b0, 2, 3);
    run(T_BEQ, 6'b000100, 6'h20, 1'b1, 0, 0);
    run(T_BEQ, 6'b000100, 6'h20, 1'b0, 0, 0);
    run(T_UNK, 6'b111111, 6'h20, 1'b0, 1, 0);
    // sw abandoned by reset while waiting in MEMWRITE
    op = 6'b101011;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    #2;
    check("mw_pre_rst", 32'({mem_write, state}), 32'({1'b1, 4'd5}));
    rst_n = 1'b0;
    #1;
    check("mw_rst", 32'({pc_en, ir_write, reg_write, mem_write}), 32'd0);
    check("mw_rst_state", 32'(state), 32'd0);
    check("mw_rst_count", instr_count, 32'd0);
    cnt_m = 32'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      t = int'($urandom_range(0, 6));
      o = t == T_UNK ? 6'($urandom_range(0, 63)) : ops[t];
      if (t == T_UNK && (o inside {6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010}))
        o = 6'b111111;
      fs = int'($urandom_range(0, 3));
      ms = int'($urandom_range(0, 3));
      run(t, o, fl[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), fs, ms);
    end
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    cnt_m = 32'hFFFF_FFFF;
    run(T_J, 6'b000010, 6'h20, 1'b0, 0, 0);
    check("wrap", instr_count, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
